// File: rtl/lamp_alarm_ctrl_pkg.sv
// Shared types and default lamp codes for the lamp-sequence alarm.
// Holds the controller state enum and the code constants.
package lamp_alarm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT0   = 3'd1,
    S_GOT1    = 3'd2,
    S_GOT2    = 3'd3,
    S_ALARM   = 3'd4,
    S_LOCKOUT = 3'd5
  } lac_state_t;

  localparam logic [1:0] LAC_CODE0 = 2'b01;
  localparam logic [1:0] LAC_CODE1 = 2'b10;
  localparam logic [1:0] LAC_CODE2 = 2'b11;

endpackage

// File: rtl/lamp_alarm_ctrl_lockout_timer.sv
// Tamper lockout timer: load with LOCK_CYCLES-1, count down, flag zero.
// Ports: CLK, RST (async low), load, dec, done.
module lac_lockout_timer #(
  parameter int LOCK_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOCK_CYCLES - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lamp_alarm_ctrl.sv
// Armed lamp-sequence alarm controller with ack and tamper lockout.
// Ports: CLK, RST, ARM, SAMPLE, SW, ACK -> ALARM, ARMED, TAMPER, STEP, FAILS.
module lamp_alarm_ctrl
  import lamp_alarm_ctrl_pkg::*;
#(
  parameter logic [1:0] CODE0       = LAC_CODE0,
  parameter logic [1:0] CODE1       = LAC_CODE1,
  parameter logic [1:0] CODE2       = LAC_CODE2,
  parameter int         MAX_FAIL    = 3,
  parameter int         LOCK_CYCLES = 8,
  localparam int        FW          = $clog2(MAX_FAIL + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ARM,
  input  logic          SAMPLE,
  input  logic [1:0]    SW,
  input  logic          ACK,
  output logic          ALARM,
  output logic          ARMED,
  output logic          TAMPER,
  output logic [1:0]    STEP,
  output logic [FW-1:0] FAILS
);

  if (CODE0 == 2'b00 || CODE1 == 2'b00 || CODE2 == 2'b00 ||
      CODE0 == CODE1 || CODE1 == CODE2 || CODE0 == CODE2)
  begin : g_bad_codes
    $fatal(1, "lamp codes must be distinct and nonzero");
  end

  if (MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_bad_limits
    $fatal(1, "MAX_FAIL and LOCK_CYCLES must be at least 1");
  end

  lac_state_t    state, state_d;
  logic [FW-1:0] fails_d, fails_inc;
  logic [1:0]    exp_code, prev_code;
  logic          hit, zero, rep;
  logic          t_load, t_dec, t_done;
  logic          alarm_d, armed_d, tamper_d;
  logic [1:0]    step_d;

  lac_lockout_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_timer (
    .CLK (CLK),
    .RST (RST),
    .load(t_load),
    .dec (t_dec),
    .done(t_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      FAILS <= '0;
    end else begin
      state <= state_d;
      FAILS <= fails_d;
    end
  end

  assign fails_inc = FAILS + 1'b1;

  // WAIT0 has no previous code, so rep can never fire there.
  always_comb begin
    exp_code  = CODE0;
    prev_code = CODE0;
    rep       = 1'b0;
    unique case (state)
      S_GOT1: begin
        exp_code = CODE1;
        rep      = (SW == CODE0);
      end
      S_GOT2: begin
        exp_code  = CODE2;
        prev_code = CODE1;
        rep       = (SW == CODE1);
      end
      default: ;
    endcase
    hit  = (SW == exp_code);
    zero = (SW == 2'b00);
  end

  always_comb begin
    state_d = state;
    fails_d = FAILS;
    unique case (state)
      S_IDLE: begin
        if (ARM) state_d = S_WAIT0;
      end
      S_WAIT0, S_GOT1, S_GOT2: begin
        if (!ARM) begin
          state_d = S_IDLE;
        end else if (SAMPLE) begin
          unique case (1'b1)
            hit: begin
              fails_d = '0;
              unique case (state)
                S_WAIT0: state_d = S_GOT1;
                S_GOT1:  state_d = S_GOT2;
                default: state_d = S_ALARM;
              endcase
            end
            zero, rep: ;
            default: begin
              fails_d = fails_inc;
              state_d = (fails_inc == FW'(MAX_FAIL)) ?
                        S_LOCKOUT : S_WAIT0;
            end
          endcase
        end
      end
      S_ALARM: begin
        if (ACK) state_d = ARM ? S_WAIT0 : S_IDLE;
      end
      S_LOCKOUT: begin
        if (t_done) begin
          fails_d = '0;
          state_d = ARM ? S_WAIT0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign t_load = (state_d == S_LOCKOUT) && (state != S_LOCKOUT);
  assign t_dec  = (state == S_LOCKOUT);

  // Outputs decode the next state so they land with the state register.
  always_comb begin
    alarm_d  = 1'b0;
    armed_d  = 1'b0;
    tamper_d = 1'b0;
    step_d   = 2'd0;
    unique case (state_d)
      S_WAIT0: armed_d = 1'b1;
      S_GOT1: begin
        armed_d = 1'b1;
        step_d  = 2'd1;
      end
      S_GOT2: begin
        armed_d = 1'b1;
        step_d  = 2'd2;
      end
      S_ALARM:   alarm_d  = 1'b1;
      S_LOCKOUT: tamper_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALARM  <= 1'b0;
      ARMED  <= 1'b0;
      TAMPER <= 1'b0;
      STEP   <= 2'd0;
    end else begin
      ALARM  <= alarm_d;
      ARMED  <= armed_d;
      TAMPER <= tamper_d;
      STEP   <= step_d;
    end
  end

endmodule

// File: tb/tb_lamp_alarm_ctrl.sv
// Directed self-checking bench for lamp_alarm_ctrl.
// Drives after the falling edge, checks on the falling edge.
module tb_lamp_alarm_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ARM = 1'b0;
  logic       SAMPLE = 1'b0;
  logic [1:0] SW = 2'b00;
  logic       ACK = 1'b0;
  logic       ALARM, ARMED, TAMPER;
  logic [1:0] STEP;
  logic [1:0] FAILS;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 CLK = ~CLK;

  lamp_alarm_ctrl dut (
    .CLK   (CLK),
    .RST   (RST),
    .ARM   (ARM),
    .SAMPLE(SAMPLE),
    .SW    (SW),
    .ACK   (ACK),
    .ALARM (ALARM),
    .ARMED (ARMED),
    .TAMPER(TAMPER),
    .STEP  (STEP),
    .FAILS (FAILS)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic s,
                     input logic [1:0] w, input logic k);
    ARM = a;
    SAMPLE = s;
    SW = w;
    ACK = k;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_all(input string tag, input logic al,
                         input logic ar, input logic tp,
                         input logic [1:0] st, input logic [1:0] fl);
    chk({tag, ".alarm"}, 32'(ALARM), 32'(al));
    chk({tag, ".armed"}, 32'(ARMED), 32'(ar));
    chk({tag, ".tamper"}, 32'(TAMPER), 32'(tp));
    chk({tag, ".step"}, 32'(STEP), 32'(st));
    chk({tag, ".fails"}, 32'(FAILS), 32'(fl));
  endtask

  initial begin
    @(negedge CLK);
    chk_all("reset", 0, 0, 0, 0, 0);
    RST = 1'b1;

    cyc(1, 0, 2'b00, 0);
    chk_all("arm", 0, 1, 0, 0, 0);
    cyc(1, 1, 2'b01, 0);
    chk_all("s1", 0, 1, 0, 1, 0);
    cyc(1, 1, 2'b10, 0);
    chk_all("s2", 0, 1, 0, 2, 0);
    cyc(1, 1, 2'b11, 0);
    chk_all("s3", 1, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0);
    chk("alarm_hold", 32'(ALARM), 32'd1);
    cyc(1, 0, 2'b00, 1);
    chk_all("ack", 0, 1, 0, 0, 0);

    cyc(1, 1, 2'b01, 0);
    chk("ign.a", 32'(STEP), 32'd1);
    cyc(1, 1, 2'b00, 0);
    chk("ign.zero1", 32'(STEP), 32'd1);
    cyc(1, 1, 2'b01, 0);
    chk_all("ign.rep", 0, 1, 0, 1, 0);
    cyc(1, 1, 2'b10, 0);
    chk("ign.b", 32'(STEP), 32'd2);
    cyc(1, 1, 2'b00, 0);
    chk("ign.zero2", 32'(STEP), 32'd2);
    cyc(1, 1, 2'b11, 0);
    chk_all("ign.alarm", 1, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 1);
    chk("ign.ack", 32'(ALARM), 32'd0);

    cyc(1, 1, 2'b10, 0);
    chk_all("wrong1", 0, 1, 0, 0, 1);
    cyc(1, 1, 2'b10, 0);
    chk_all("wrong2", 0, 1, 0, 0, 2);
    cyc(1, 1, 2'b10, 0);
    chk_all("wrong3", 0, 0, 1, 0, 3);
    n = 1;
    for (int i = 0; i < 20 && TAMPER; i++) begin
      cyc(1, 1, 2'b01, 1);
      if (TAMPER) n++;
    end
    chk("lock.len", 32'(n), 32'd8);
    chk_all("lock.end", 0, 1, 0, 0, 0);

    cyc(1, 1, 2'b01, 0);
    cyc(1, 1, 2'b10, 0);
    chk("disarm.pre", 32'(STEP), 32'd2);
    cyc(0, 1, 2'b11, 0);
    chk_all("disarm", 0, 0, 0, 0, 0);

    cyc(1, 0, 2'b00, 0);
    cyc(1, 1, 2'b11, 0);
    cyc(1, 1, 2'b11, 0);
    chk("rl.fails", 32'(FAILS), 32'd2);
    cyc(1, 1, 2'b11, 0);
    chk("rl.c1", 32'(TAMPER), 32'd1);
    cyc(1, 0, 2'b00, 0);
    cyc(1, 0, 2'b00, 0);
    chk("rl.c3", 32'(TAMPER), 32'd1);
    RST = 1'b0;
    #1;
    chk_all("rl.rst", 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    cyc(0, 0, 2'b00, 0);
    chk_all("rl.idle", 0, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0);
    chk_all("rl.arm", 0, 1, 0, 0, 0);

    cyc(1, 1, 2'b01, 1);
    cyc(1, 1, 2'b10, 1);
    cyc(1, 1, 2'b11, 1);
    chk_all("ackhi.on", 1, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 1);
    chk_all("ackhi.off", 0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_alarm_ctrl.md
# lamp_alarm_ctrl

Sequencing controller for the lamp-sequence alarm. Samples the two lamp switches on a qualified strobe and steps through the code sequence CODE0 → CODE1 → CODE2. It latches ALARM on completion until acknowledged, counts wrong steps, and enters a timed tamper lockout after MAX_FAIL consecutive wrong steps. It sits between the board inputs (switches, keys) and the LED outputs, and replaces the free-running detector with an armed, acknowledged controller.

## Interface
- CODE0, 2'b01, first expected lamp code
- CODE1, 2'b10, second expected lamp code
- CODE2, 2'b11, third expected lamp code
- MAX_FAIL, 3, consecutive wrong steps that trigger lockout (≥1)
- LOCK_CYCLES, 8, lockout duration in CLK cycles (≥1)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-low
- ARM  in  1  level; 1 = detection enabled
- SAMPLE  in  1  one-cycle strobe; SW is evaluated only when SAMPLE=1
- SW  in  2  lamp code {lamp1, lamp0}
- ACK  in  1  alarm acknowledge, level-sampled
- ALARM  out  1  sequence completed, latched until ACK
- ARMED  out  1  controller is in a detection state
- TAMPER  out  1  lockout in progress
- STEP  out  2  codes matched so far (0–2)
- FAILS  out  $clog2(MAX_FAIL+1)  consecutive wrong-step count

## Operation
- States: IDLE, WAIT0, GOT1, GOT2, ALARM, LOCKOUT.
- Reset values: state IDLE; ALARM=0, ARMED=0, TAMPER=0, STEP=0, FAILS=0; lockout counter 0.
- IDLE: ARM=1 → WAIT0. SAMPLE is ignored.
- Detection states are WAIT0 (STEP=0), GOT1 (STEP=1) and GOT2 (STEP=2). ARMED=1 in these states. On SAMPLE:
  - SW equals the expected code: advance WAIT0→GOT1→GOT2→ALARM and clear FAILS.
  - SW=2'b00 (all lamps off): ignored, no state change.
  - SW equals the previously matched code (repeat): hold in the current state.
  - Any other SW is a wrong step. FAILS increments and the state returns to WAIT0. If the incremented value equals MAX_FAIL, go to LOCKOUT instead.
- ARM=0 in any detection state → IDLE and STEP=0. FAILS is kept. ARM=0 has priority over a simultaneous SAMPLE.
- ALARM state: ALARM=1, ARMED=0, STEP=0. ARM and SAMPLE are ignored. ACK=1 → WAIT0 if ARM=1, else IDLE.
- LOCKOUT: TAMPER=1, ARMED=0. The counter is loaded with LOCK_CYCLES-1 on entry and decrements each cycle. At 0 the controller clears FAILS and goes to WAIT0 if ARM=1, else IDLE. ACK, SAMPLE and ARM do not shorten the lockout.
- Default codes must be distinct and nonzero. This is checked by an elaboration-time assertion.

## Timing
- All outputs are registered Moore outputs: they change only after the edge that changes state.
- Latency: a SAMPLE of CODE2 while in GOT2 at edge k makes ALARM=1 from edge k onward, i.e. visible in cycle k+1.
- TAMPER is high for exactly LOCK_CYCLES cycles, starting after the edge that registered the failing SAMPLE.
- ACK while in ALARM clears ALARM after the next edge. An ACK held high across ALARM entry clears it one cycle later. ALARM always lasts at least 1 cycle.
- A SAMPLE held high for several cycles counts as one evaluation per cycle. A debounced single-cycle strobe is the upstream's responsibility.
- Asynchronous RST mid-sequence, mid-alarm or mid-lockout forces the reset values immediately. Release is synchronised externally.

## Structure
- The shared package holds the state enum (lac_state_t, 3-bit encoding) and default code constants LAC_CODE0/1/2.
- One sub-module, lac_lockout_timer: load/decrement counter of width $clog2(LOCK_CYCLES) with a done flag.
- The FSM, fail counter and output registers live in lamp_alarm_ctrl.

## Test plan
- Reset, then ARM=1 and SAMPLE SW=01, 10, 11 on consecutive strobes → STEP goes 1, 2, then ALARM=1 one cycle after the third strobe. ACK → ALARM=0 and state WAIT0.
- Sequence 01, 00, 01, 10, 00, 11 → 00s and the repeat are ignored; ALARM asserts. FAILS stays 0.
- Three wrong steps (SW=10 from WAIT0, three times) → FAILS goes 1, 2, then TAMPER=1 for exactly 8 cycles. FAILS=0 and ARMED=1 afterwards.
- ARM dropped in GOT2, with SAMPLE=11 in the same cycle → IDLE, STEP=0, ALARM stays 0.
- RST asserted in LOCKOUT cycle 3 → all outputs 0 immediately. After release, IDLE and the lockout is not resumed.
- ACK held high before completion → ALARM asserts for exactly 1 cycle, then WAIT0.
